// File: rtl/mcs4_phase_gen.sv
// Two-phase non-overlapping clock generator for the MCS-4 bus with subcycle
// tracking, SYNC generation, run/stop at instruction boundaries and single-step.
module mcs4_phase_gen #(
    parameter int unsigned PERIOD     = 7,
    parameter int unsigned PHI1_W     = 2,
    parameter int unsigned PHI2_START = 4,
    parameter int unsigned PHI2_W     = 2,
    parameter int unsigned SUBCYCLES  = 8,
    parameter int unsigned SYNC_SUB   = 7,
    localparam int unsigned CNT_W     = (PERIOD > 1) ? $clog2(PERIOD) : 1,
    localparam int unsigned SUB_W     = (SUBCYCLES > 1) ? $clog2(SUBCYCLES) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             step_i,
    output logic             PHI1_o,
    output logic             PHI2_o,
    output logic             SYNC_o,
    output logic [SUB_W-1:0] subcycle_o,
    output logic             cycle_start_o,
    output logic             running_o
);

    // Parameter sanity: both phases present with at least one gap clock around each.
    if (PHI1_W < 1 || PHI2_W < 1) begin : g_bad_width
        $fatal(1, "mcs4_phase_gen: PHI1_W and PHI2_W must be >= 1");
    end
    if (PHI2_START < PHI1_W + 1) begin : g_bad_phi2_start
        $fatal(1, "mcs4_phase_gen: PHI2_START must be >= PHI1_W+1");
    end
    if (PHI2_START + PHI2_W + 1 > PERIOD) begin : g_bad_phi2_end
        $fatal(1, "mcs4_phase_gen: PHI2_START+PHI2_W must be <= PERIOD-1");
    end
    if (SYNC_SUB + 1 > SUBCYCLES) begin : g_bad_sync
        $fatal(1, "mcs4_phase_gen: SYNC_SUB must be < SUBCYCLES");
    end

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUB_W-1:0] sub_q, sub_d;

    logic             phi1_q, phi1_d;
    logic             phi2_q, phi2_d;
    logic             sync_q, sync_d;
    logic             cstart_q, cstart_d;
    logic             active_q, active_d;
    logic [SUB_W-1:0] subcycle_q;

    logic last_cnt;
    logic boundary;

    assign last_cnt = (cnt_q == CNT_W'(PERIOD - 1));
    assign boundary = last_cnt && (sub_q == SUB_W'(SUBCYCLES - 1));

    // Next-state and counter update; run_i only matters at the instruction boundary.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        case (state_q)
            ST_STOPPED: begin
                cnt_d = '0;
                sub_d = '0;
                if (run_i) begin
                    state_d = ST_RUNNING;
                end else if (step_i) begin
                    state_d = ST_STEPPING;
                end
            end
            ST_RUNNING, ST_STEPPING: begin
                if (last_cnt) begin
                    cnt_d = '0;
                    if (boundary) begin
                        sub_d   = '0;
                        state_d = run_i ? ST_RUNNING : ST_STOPPED;
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STOPPED;
                cnt_d   = '0;
                sub_d   = '0;
            end
        endcase
    end

    // Output decode from the values about to be loaded, so outputs align with the counters.
    always_comb begin
        active_d = (state_d != ST_STOPPED);
        phi1_d   = active_d && (32'(cnt_d) < PHI1_W);
        phi2_d   = active_d && (32'(cnt_d) >= PHI2_START) && (32'(cnt_d) < PHI2_START + PHI2_W);
        sync_d   = active_d && (32'(sub_d) == SYNC_SUB);
        cstart_d = active_d && (cnt_d == '0) && (sub_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_STOPPED;
            cnt_q      <= '0;
            sub_q      <= '0;
            phi1_q     <= 1'b0;
            phi2_q     <= 1'b0;
            sync_q     <= 1'b0;
            cstart_q   <= 1'b0;
            active_q   <= 1'b0;
            subcycle_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sub_q      <= sub_d;
            phi1_q     <= phi1_d;
            phi2_q     <= phi2_d;
            sync_q     <= sync_d;
            cstart_q   <= cstart_d;
            active_q   <= active_d;
            subcycle_q <= sub_d;
        end
    end

    assign PHI1_o        = phi1_q;
    assign PHI2_o        = phi2_q;
    assign SYNC_o        = sync_q;
    assign cycle_start_o = cstart_q;
    assign running_o     = active_q;
    assign subcycle_o    = subcycle_q;

endmodule

// File: tb/tb_mcs4_phase_gen.sv
// Directed bench for mcs4_phase_gen: default timing instance plus an overridden-parameter instance.
module tb_mcs4_phase_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       run;
    logic       step;
    logic       run6;

    logic       phi1, phi2, sync, cstart, running;
    logic [2:0] sub;
    logic       phi1_b, phi2_b, sync_b, cstart_b, running_b;
    logic [1:0] sub_b;

    int n_checks = 0;
    int n_errors = 0;

    int c_p1, c_p2, c_sync, c_cs;
    logic p1_prev, p2_prev, sync_prev;

    mcs4_phase_gen dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .run_i        (run),
        .step_i       (step),
        .PHI1_o       (phi1),
        .PHI2_o       (phi2),
        .SYNC_o       (sync),
        .subcycle_o   (sub),
        .cycle_start_o(cstart),
        .running_o    (running)
    );

    mcs4_phase_gen #(
        .PERIOD    (10),
        .PHI1_W    (3),
        .PHI2_START(5),
        .PHI2_W    (3),
        .SUBCYCLES (4),
        .SYNC_SUB  (0)
    ) dut6 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .run_i        (run6),
        .step_i       (1'b0),
        .PHI1_o       (phi1_b),
        .PHI2_o       (phi2_b),
        .SYNC_o       (sync_b),
        .subcycle_o   (sub_b),
        .cycle_start_o(cstart_b),
        .running_o    (running_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed outputs packed {phi1,phi2,sync,cstart,running} against an arithmetic model.
    task automatic check_gen(input string tag, input int i,
                             input int period, input int p1w, input int p2s, input int p2w,
                             input int nsub, input int syncsub,
                             input logic [4:0] obs, input int obs_sub);
        int c, s;
        logic [4:0] exp;
        c = i % period;
        s = (i / period) % nsub;
        exp = {c < p1w, (c >= p2s) && (c < p2s + p2w), s == syncsub,
               (c == 0) && (s == 0), 1'b1};
        check($sformatf("%s_out[%0d]", tag, i), 32'(obs), 32'(exp));
        check($sformatf("%s_sub[%0d]", tag, i), 32'(obs_sub), 32'(s));
        check($sformatf("%s_overlap[%0d]", tag, i), 32'(obs[4] & obs[3]), 32'd0);
    endtask

    task automatic count_pulses();
        if (phi1 && !p1_prev) c_p1++;
        if (phi2 && !p2_prev) c_p2++;
        if (sync && !sync_prev) c_sync++;
        if (cstart) c_cs++;
        p1_prev   = phi1;
        p2_prev   = phi2;
        sync_prev = sync;
    endtask

    task automatic clear_counts();
        c_p1 = 0; c_p2 = 0; c_sync = 0; c_cs = 0;
    endtask

    task automatic main_step(input string tag, input int i);
        tick();
        count_pulses();
        check_gen(tag, i, 7, 2, 4, 2, 8, 7, {phi1, phi2, sync, cstart, running}, int'(sub));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out"}, 32'({phi1, phi2, sync, cstart, running}), 32'd0);
        check({tag, "_sub"}, 32'(sub), 32'd0);
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            count_pulses();
            check_idle($sformatf("%s[%0d]", tag, k));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        run6  = 1'b0;
        p1_prev = 1'b0; p2_prev = 1'b0; sync_prev = 1'b0;
        clear_counts();
        repeat (2) tick();
        check_idle("reset");
        check("reset_b", 32'({phi1_b, phi2_b, sync_b, cstart_b, running_b, sub_b}), 32'd0);

        // Out of reset with run low: stays stopped.
        @(negedge clk);
        rst_n = 1'b1;
        idle_steps("idle_after_reset", 3);

        // Free run for three instructions, drop run during subcycle 3 of the third.
        run = 1'b1;
        for (int i = 0; i < 168; i++) begin
            if (i == 112) clear_counts();
            main_step("run", i);
            if (i == 136) run = 1'b0;
        end
        check("run_phi1_pulses_last_instr", 32'(c_p1), 32'd8);
        check("run_phi2_pulses_last_instr", 32'(c_p2), 32'd8);
        check("run_sync_windows_last_instr", 32'(c_sync), 32'd1);
        idle_steps("stop_after_boundary", 4);

        // Single step, with a second step pulse mid-instruction that must be ignored.
        clear_counts();
        step = 1'b1;
        for (int i = 0; i < 56; i++) begin
            main_step("step", i);
            if (i == 0) step = 1'b0;
            if (i == 10) step = 1'b1;
            if (i == 11) step = 1'b0;
        end
        idle_steps("stop_after_step", 4);
        check("step_phi1_pulses", 32'(c_p1), 32'd8);
        check("step_phi2_pulses", 32'(c_p2), 32'd8);
        check("step_sync_windows", 32'(c_sync), 32'd1);
        check("step_cycle_starts", 32'(c_cs), 32'd1);

        // run and step together: run wins and continues past one instruction.
        run  = 1'b1;
        step = 1'b1;
        for (int i = 0; i < 112; i++) begin
            main_step("run_and_step", i);
            if (i == 0) step = 1'b0;
            if (i == 69) run = 1'b0;
        end
        idle_steps("stop_after_run_and_step", 3);

        // Asynchronous reset while PHI2 is high.
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            main_step("pre_reset", i);
        end
        run = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle_steps("after_async_reset", 5);

        // Overridden timing instance: 10-clock subcycle, 4 subcycles, SYNC in sub 0.
        run6 = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            check_gen("p10", i, 10, 3, 5, 3, 4, 0,
                      {phi1_b, phi2_b, sync_b, cstart_b, running_b}, int'(sub_b));
            if (i == 45) run6 = 1'b0;
        end
        tick();
        check("p10_stopped", 32'({phi1_b, phi2_b, sync_b, cstart_b, running_b, sub_b}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
